// File: rtl/alu_pkg.sv
// Shared ALU command definitions: opcode encoding, operand widths and the
// packed command layout used on the queue-to-ALU interface.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    XOR = 2'd3
  } alu_op_e;

  localparam int OPND_W = 4;
  localparam int OP_W   = 2;
  localparam int CMD_W  = OP_W + 2 * OPND_W;

  localparam int A_LSB  = 0;
  localparam int B_LSB  = A_LSB + OPND_W;
  localparam int OP_LSB = B_LSB + OPND_W;

  // Field order gives a at [3:0], b at [7:4], op at [9:8].
  typedef struct packed {
    alu_op_e             op;
    logic [OPND_W-1:0]   b;
    logic [OPND_W-1:0]   a;
  } alu_cmd_t;

  function automatic alu_cmd_t pack_cmd(logic [OP_W-1:0] op,
                                        logic [OPND_W-1:0] a,
                                        logic [OPND_W-1:0] b);
    alu_cmd_t c;
    c.op = alu_op_e'(op);
    c.b  = b;
    c.a  = a;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides. Occupancy is a register,
// so wready/rvalid depend only on state and never on same-cycle inputs.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    count;
  logic             push, pop;

  assign wready = (count != LW'(DEPTH));
  assign rvalid = (count != '0);
  assign push   = wvalid && wready;
  assign pop    = rvalid && rready;
  assign rdata  = mem[rptr];
  assign level  = count;

  // Storage is cleared on reset so rdata is never X, even while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Buffers host ALU commands in order, packs them into the shared command
// layout and counts commands handed to the ALU.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [OPND_W-1:0]        in_a,
  input  logic [OPND_W-1:0]        in_b,
  output logic                     rvalid,
  output logic [CMD_W-1:0]         rdata,
  input  logic                     rready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued
);

  alu_cmd_t cmd;

  assign cmd = pack_cmd(in_op, in_a, in_b);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wvalid (in_valid),
    .wready (in_ready),
    .wdata  (cmd),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .level  (level)
  );

  // Free-running wrap at 2^CNT_W is intended.
  always_ff @(posedge clk) begin
    if (reset)                issued <= '0;
    else if (rvalid && rready) issued <= issued + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomised and directed bench for alu_cmd_queue against a queue-based model;
// a second instance with a 2-bit counter shares the stimulus.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       rready = 1'b0;
  logic [1:0] in_op = '0;
  logic [3:0] in_a = '0, in_b = '0;

  logic          in_ready, rvalid, in_ready2, rvalid2;
  logic [9:0]    rdata, rdata2;
  logic [LW-1:0] level, level2;
  logic [7:0]    issued;
  logic [1:0]    issued2;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: list of pending commands plus an unbounded issue count.
  logic [9:0] mq[$];
  int         m_issued = 0;
  bit         last_pop;
  logic [9:0] fill_cmds [5];

  alu_cmd_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .rvalid(rvalid), .rdata(rdata),
    .rready(rready), .level(level), .issued(issued));

  alu_cmd_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .rvalid(rvalid2), .rdata(rdata2),
    .rready(rready), .level(level2), .issued(issued2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] mk(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    return {op, b, a};
  endfunction

  task automatic set_cmd(logic [9:0] c);
    in_a  = c[3:0];
    in_b  = c[7:4];
    in_op = c[9:8];
  endtask

  // One clock: model decides push/pop from pre-edge inputs, then updates.
  task automatic cycle();
    bit push, pop;
    logic [9:0] c;
    push = in_valid && (mq.size() != DEPTH);
    pop  = rready && (mq.size() != 0);
    c    = {in_op, in_b, in_a};
    @(posedge clk);
    last_pop = 1'b0;
    if (reset) begin
      mq.delete();
      m_issued = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_issued++;
        last_pop = 1'b1;
      end
      if (push) mq.push_back(c);
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rready   = 1'b0;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (issued !== 8'd0) $display("FAIL reset_issued got %0d want 0", issued); else pass_cnt++;
    total_cnt++; if (rdata !== 10'd0) $display("FAIL reset_rdata got %h want 000", rdata); else pass_cnt++;
    total_cnt++; if (issued2 !== 2'd0) $display("FAIL reset_issued2 got %0d want 0", issued2); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    rready = 1'b1;
    in_valid = 1'b1;
    set_cmd(mk(2'd0, 4'd3, 4'd5));
    cycle();
    in_valid = 1'b0;
    total_cnt++; if (rvalid !== 1'b1) $display("FAIL single_rvalid got %b want 1", rvalid); else pass_cnt++;
    total_cnt++; if (rdata !== 10'h053) $display("FAIL single_rdata got %h want 053", rdata); else pass_cnt++;
    cycle();
    total_cnt++; if (issued !== 8'd1) $display("FAIL single_issued got %0d want 1", issued); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL single_level got %0d want 0", level); else pass_cnt++;
  endtask

  task automatic test_fill();
    int exp_lvl;
    do_reset();
    rready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fill_cmds[i] = 10'($urandom);
      set_cmd(fill_cmds[i]);
      cycle();
      exp_lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
      total_cnt++; if (level !== LW'(exp_lvl)) $display("FAIL fill_level[%0d] got %0d want %0d", i, level, exp_lvl); else pass_cnt++;
      total_cnt++; if (in_ready !== (exp_lvl != DEPTH)) $display("FAIL fill_in_ready[%0d] got %b want %b", i, in_ready, exp_lvl != DEPTH); else pass_cnt++;
      total_cnt++; if (rdata !== fill_cmds[0]) $display("FAIL fill_rdata_hold[%0d] got %h want %h", i, rdata, fill_cmds[0]); else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  // Continues from the full queue left by test_fill.
  task automatic test_drain();
    rready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (rdata !== fill_cmds[i]) $display("FAIL drain_order[%0d] got %h want %h", i, rdata, fill_cmds[i]); else pass_cnt++;
      cycle();
      if (i == 0) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready got %b want 1", in_ready); else pass_cnt++;
      end
    end
    total_cnt++; if (issued !== 8'd4) $display("FAIL drain_issued got %0d want 4", issued); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL drain_rvalid got %b want 0", rvalid); else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [9:0] c [3];
    do_reset();
    for (int i = 0; i < 3; i++) c[i] = 10'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_cmd(c[i]);
      cycle();
    end
    set_cmd(c[2]);
    rready = 1'b1;
    cycle();
    in_valid = 1'b0;
    total_cnt++; if (level !== 3'd2) $display("FAIL pushpop_level got %0d want 2", level); else pass_cnt++;
    total_cnt++; if (rdata !== c[1]) $display("FAIL pushpop_rdata got %h want %h", rdata, c[1]); else pass_cnt++;
    cycle();
    total_cnt++; if (rdata !== c[2]) $display("FAIL pushpop_next got %h want %h", rdata, c[2]); else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [9:0] c [5];
    do_reset();
    for (int i = 0; i < 5; i++) c[i] = 10'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(c[i]);
      cycle();
    end
    set_cmd(c[4]);
    rready = 1'b1;
    cycle();
    total_cnt++; if (level !== 3'd3) $display("FAIL fullpop_level got %0d want 3", level); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL fullpop_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (rdata !== c[1]) $display("FAIL fullpop_rdata got %h want %h", rdata, c[1]); else pass_cnt++;
    rready = 1'b0;
    cycle();
    in_valid = 1'b0;
    total_cnt++; if (level !== 3'd4) $display("FAIL fullpop_refill got %0d want 4", level); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(10'($urandom));
      cycle();
    end
    total_cnt++; if (level !== 3'd3) $display("FAIL midrst_pre_level got %0d want 3", level); else pass_cnt++;
    rready = 1'b1;
    reset  = 1'b1;
    cycle();
    reset    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL midrst_rvalid got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL midrst_level got %0d want 0", level); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (issued !== 8'd0) $display("FAIL midrst_issued got %0d want 0", issued); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total_cnt++; if (rvalid !== 1'b0 || issued !== 8'd0) $display("FAIL midrst_stale[%0d] got rvalid=%b issued=%0d want 0/0", i, rvalid, issued); else pass_cnt++;
    end
    rready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    int k = 0;
    do_reset();
    in_valid = 1'b1;
    rready   = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      set_cmd(10'($urandom));
      cycle();
      if (last_pop) begin
        total_cnt++; if (issued2 !== 2'(seq[k])) $display("FAIL wrap_issued2[%0d] got %0d want %0d", k, issued2, seq[k]); else pass_cnt++;
        total_cnt++; if (issued !== 8'(k + 1)) $display("FAIL wrap_issued[%0d] got %0d want %0d", k, issued, k + 1); else pass_cnt++;
        k++;
      end
    end
    total_cnt++; if (k != 5) $display("FAIL wrap_timeout got %0d pops want 5", k); else pass_cnt++;
    in_valid = 1'b0;
    rready   = 1'b0;
  endtask

  task automatic test_random();
    bit rr_bias;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) rr_bias = $urandom_range(0, 1) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      rready   = rr_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset    = $urandom_range(0, 99) == 0;
      set_cmd(10'($urandom));
      cycle();
      reset = 1'b0;
      total_cnt++; if (level !== LW'(mq.size())) $display("FAIL rand_level[%0d] got %0d want %0d", i, level, mq.size()); else pass_cnt++;
      total_cnt++; if (rvalid !== (mq.size() != 0)) $display("FAIL rand_rvalid[%0d] got %b want %b", i, rvalid, mq.size() != 0); else pass_cnt++;
      total_cnt++; if (in_ready !== (mq.size() != DEPTH)) $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, mq.size() != DEPTH); else pass_cnt++;
      total_cnt++; if (issued !== 8'(m_issued % 256)) $display("FAIL rand_issued[%0d] got %0d want %0d", i, issued, m_issued % 256); else pass_cnt++;
      total_cnt++; if (issued2 !== 2'(m_issued % 4)) $display("FAIL rand_issued2[%0d] got %0d want %0d", i, issued2, m_issued % 4); else pass_cnt++;
      total_cnt++; if ({in_ready2, rvalid2, level2} !== {in_ready, rvalid, level}) $display("FAIL rand_dut2_state[%0d] got %b want %b", i, {in_ready2, rvalid2, level2}, {in_ready, rvalid, level}); else pass_cnt++;
      if (mq.size() != 0) begin
        total_cnt++; if (rdata !== mq[0]) $display("FAIL rand_rdata[%0d] got %h want %h", i, rdata, mq[0]); else pass_cnt++;
        total_cnt++; if (rdata2 !== mq[0]) $display("FAIL rand_rdata2[%0d] got %h want %h", i, rdata2, mq[0]); else pass_cnt++;
      end
      total_cnt++; if ($isunknown(rdata)) $display("FAIL rand_rdata_x[%0d] got %h want known", i, rdata); else pass_cnt++;
    end
    in_valid = 1'b0;
    rready   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_push_pop();
    test_full_pop();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered commands; power of two, >= 2.
REQ-002 Parameter: CNT_W, default 8, width of the issued-command counter.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  host command valid.
REQ-006 in_ready  output  1  queue can accept a command this cycle.
REQ-007 in_op  input  2  operation: 0 add, 1 sub, 2 mul, 3 xor.
REQ-008 in_a  input  4  operand 1.
REQ-009 in_b  input  4  operand 2.
REQ-010 rvalid  output  1  packed command valid toward the ALU.
REQ-011 rdata  output  10  packed command toward the ALU.
REQ-012 rready  input  1  ALU accepts the command.
REQ-013 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 issued  output  CNT_W  commands handed to the ALU since reset.

Function
REQ-015 Packing SHALL be rdata[3:0]=a, rdata[7:4]=b, rdata[9:8]=op; no other transform.
REQ-016 Push occurs on a rising edge with in_valid && in_ready; pop occurs with rvalid && rready.
REQ-017 in_ready SHALL equal (level != DEPTH), driven from registered state only; no same-cycle pass-through when full.
REQ-018 rvalid SHALL equal (level != 0); rdata SHALL present the oldest entry.
REQ-019 Latency: a push into an empty queue SHALL raise rvalid on the following cycle, with rdata equal to that command.
REQ-020 While rvalid is high and rready is low, rdata and rvalid SHALL hold stable.
REQ-021 Ordering SHALL be strict FIFO; no reordering by op, including mul.
REQ-022 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-023 Simultaneous push and pop at level 0 is impossible (rvalid low); only the push takes effect.
REQ-024 At level DEPTH, in_valid SHALL be ignored (in_ready low) even if a pop occurs that cycle; the slot is usable next cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 issued SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0.
REQ-027 rdata when rvalid is low is don't-care but SHALL NOT be X after reset (holds last or zero).

Reset
REQ-028 On reset: level=0, pointers=0, rvalid=0, in_ready=1, issued=0, rdata=0.
REQ-029 Reset mid-operation SHALL flush all buffered commands; none are issued afterward.
REQ-030 Reset takes priority over simultaneous push/pop in the same cycle.

Structure
REQ-031 Package alu_pkg SHALL hold alu_op_e (ADD=0, SUB=1, MUL=2, XOR=3), OPND_W=4, OP_W=2, CMD_W=10 and the packing field offsets; the ALU and this block share it.
REQ-032 Storage SHALL be one sub-module sync_fifo (parameterised width/depth, registered occupancy); alu_cmd_queue adds packing and the issued counter.

Verification
REQ-033 Reset then push op=0,a=3,b=5 with rready=1 -> rvalid high next cycle, rdata=10'h053, popped, issued=1, level=0.
REQ-034 rready=0, push 5 commands back-to-back -> level=4, in_ready low after 4th, 5th not accepted; rdata holds first command.
REQ-035 Full queue, release rready for 4 cycles -> commands emerge in push order, issued=4, in_ready re-asserts the cycle after the first pop.
REQ-036 level=2, push and pop in the same cycle -> level stays 2, next rdata is the 2nd-oldest entry.
REQ-037 Assert reset with level=3 -> next cycle rvalid=0, level=0, in_ready=1, issued=0; no stale command appears later.
REQ-038 CNT_W=2, issue 5 commands -> issued sequence 1,2,3,0,1.
